// File: rtl/irq_ctrl.sv
// Interrupt controller: syncs, qualifies, masks and prioritizes N_SRC sources into one CP0 request.
// Optional IRQ_SYNC_EN adds a two-flop synchronizer per source (latency S=2).
module irq_ctrl #(
    parameter int N_SRC = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] irq_src,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_din,
    output logic [31:0]      cfg_dout,
    output logic             ir_out,
    input  logic             ir_ack,
    output logic [2:0]       irq_id
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SVC} state_t;

    state_t           r_state, w_state_nxt;
    logic [N_SRC-1:0] w_src, r_hist, r_pend, r_mask, r_mode;
    logic [N_SRC-1:0] w_pend, w_elig, w_rise, w_clr;
    logic [2:0]       w_win, r_id;
    logic             r_ir_out;
    logic             w_wr_pend, w_eoi, w_claim;

`ifdef IRQ_SYNC_EN
    logic [N_SRC-1:0] r_sync1, r_sync2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= irq_src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src = r_sync2;
`else
    assign w_src = irq_src;
`endif

    assign w_wr_pend = cfg_we && (cfg_addr == 2'd0);
    assign w_eoi     = cfg_we && (cfg_addr == 2'd3);
    assign w_claim   = (r_state == ST_REQ) && ir_ack;

    // Level bits read the live input; edge bits read the sticky flop.
    assign w_pend = (r_pend & r_mode) | (w_src & ~r_mode);
    assign w_elig = w_pend & r_mask;
    assign w_rise = w_src & ~r_hist;

    always_comb begin
        w_clr = '0;
        if (w_wr_pend) w_clr = cfg_din[N_SRC-1:0];
        if (w_claim)   w_clr[r_id] = 1'b1;
    end

    always_comb begin
        w_win = '0;
        for (int i = N_SRC - 1; i >= 0; i--)
            if (w_elig[i]) w_win = 3'(i);
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (|w_elig) w_state_nxt = ST_REQ;
            // Ack beats a simultaneous loss of eligibility.
            ST_REQ: begin
                if (ir_ack)             w_state_nxt = ST_SVC;
                else if (!w_elig[r_id]) w_state_nxt = ST_IDLE;
            end
            ST_SVC:  if (w_eoi) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_ir_out <= 1'b0;
            r_id     <= '0;
            r_hist   <= '0;
            r_pend   <= '0;
            r_mask   <= '0;
            r_mode   <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ir_out <= (w_state_nxt == ST_REQ);
            if (r_state == ST_IDLE && |w_elig) r_id <= w_win;
            r_hist   <= w_src;
            // Set wins over claim/W1C; level-mode bits keep no sticky state.
            r_pend   <= ((r_pend & ~w_clr) | w_rise) & r_mode;
            if (cfg_we && cfg_addr == 2'd1) r_mask <= cfg_din[N_SRC-1:0];
            if (cfg_we && cfg_addr == 2'd2) r_mode <= cfg_din[N_SRC-1:0];
        end
    end

    always_comb begin
        cfg_dout = '0;
        case (cfg_addr)
            2'd0: cfg_dout = 32'(w_pend);
            2'd1: cfg_dout = 32'(r_mask);
            2'd2: cfg_dout = 32'(r_mode);
            2'd3: cfg_dout = {28'b0, (r_state == ST_SVC), r_id};
            default: cfg_dout = '0;
        endcase
    end

    assign ir_out = r_ir_out;
    assign irq_id = r_id;

endmodule

// File: tb/tb_irq_ctrl.sv
// Bench for irq_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a behavioural model.
module tb_irq_ctrl;

`ifdef IRQ_SYNC_EN
    localparam int S = 2;
`else
    localparam int S = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_addr = '0;
    logic [31:0] cfg_din = '0;
    logic [31:0] cfg_dout;
    logic        ir_out;
    logic        ir_ack = 1'b0;
    logic [2:0]  irq_id;

    int n_chk = 0;
    int n_err = 0;

    irq_ctrl #(.N_SRC(8)) dut (
        .clk(clk), .rst(rst), .irq_src(irq_src), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
        .cfg_din(cfg_din), .cfg_dout(cfg_dout), .ir_out(ir_out), .ir_ack(ir_ack), .irq_id(irq_id)
    );

    always #5 clk = ~clk;

    // Behavioural model: sticky edge pending, request/service flags, latched id.
    logic [7:0] m_pe = '0, m_mask = '0, m_mode = '0, m_prev = '0, smp0 = '0, smp1 = '0;
    logic [7:0] t_src, t_pend, t_elig, t_clr;
    bit         m_req = 0, m_svc = 0;
    logic [2:0] m_id = '0;

    function automatic logic [7:0] src_now();
        return (S == 0) ? irq_src : smp1;
    endfunction

    function automatic logic [31:0] m_read(input logic [1:0] a);
        logic [7:0] p;
        p = (m_pe & m_mode) | (src_now() & ~m_mode);
        case (a)
            2'd0: return {24'b0, p};
            2'd1: return {24'b0, m_mask};
            2'd2: return {24'b0, m_mode};
            default: return {28'b0, m_svc, m_id};
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_pe = '0; m_mask = '0; m_mode = '0; m_prev = '0; smp0 = '0; smp1 = '0;
            m_req = 0; m_svc = 0; m_id = '0;
        end else begin
            t_src  = src_now();
            t_pend = (m_pe & m_mode) | (t_src & ~m_mode);
            t_elig = t_pend & m_mask;
            t_clr  = '0;
            if (cfg_we && cfg_addr == 2'd0) t_clr = cfg_din[7:0];
            if (m_req && ir_ack) t_clr[m_id] = 1'b1;
            if (!m_req && !m_svc) begin
                if (t_elig != 0) begin
                    for (int i = 7; i >= 0; i--) if (t_elig[i]) m_id = 3'(i);
                    m_req = 1;
                end
            end else if (m_req) begin
                if (ir_ack) begin m_req = 0; m_svc = 1; end
                else if (!t_elig[m_id]) m_req = 0;
            end else if (cfg_we && cfg_addr == 2'd3) begin
                m_svc = 0;
            end
            m_pe = ((m_pe & ~t_clr) | (t_src & ~m_prev)) & m_mode;
            if (cfg_we && cfg_addr == 2'd1) m_mask = cfg_din[7:0];
            if (cfg_we && cfg_addr == 2'd2) m_mode = cfg_din[7:0];
            m_prev = t_src;
            smp1 = smp0;
            smp0 = irq_src;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle compare, sampled on the falling edge before inputs move.
    always @(negedge clk) begin
        if (!rst) begin
            chk("ir_out", {31'b0, ir_out}, {31'b0, m_req});
            chk("irq_id", {29'b0, irq_id}, {29'b0, m_id});
            chk("cfg_dout", cfg_dout, m_read(cfg_addr));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_din = d;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        cfg_addr = a;
        #1;
        d = cfg_dout;
    endtask

    task automatic ack();
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
    endtask

    task automatic pulse(input logic [7:0] b);
        irq_src = b;
        tick();
        irq_src = '0;
        repeat (S) tick();
    endtask

    logic [31:0] rv;

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state and reset during REQ
        chk("rst_ir_out", {31'b0, ir_out}, 32'd0);
        rd(2'd0, rv); chk("rst_pend", rv, 32'h0);
        rd(2'd3, rv); chk("rst_stat", rv, 32'h0);
        wr(2'd1, 32'hFF);
        wr(2'd2, 32'hFF);
        pulse(8'h08);
        tick();
        chk("req_up", {31'b0, ir_out}, 32'd1);
        chk("req_id3", {29'b0, irq_id}, 32'd3);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ir_out", {31'b0, ir_out}, 32'd0);
        chk("async_rst_id", {29'b0, irq_id}, 32'd0);
        rd(2'd0, rv); chk("async_rst_pend", rv, 32'h0);
        tick();
        rst = 1'b0;
        tick();

        // Priority and handshake
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'hFF);
        pulse(8'h24);
        chk("prio_not_yet", {31'b0, ir_out}, 32'd0);
        tick();
        chk("prio_ir_out", {31'b0, ir_out}, 32'd1);
        chk("prio_id2", {29'b0, irq_id}, 32'd2);
        ack();
        chk("ack_ir_out", {31'b0, ir_out}, 32'd0);
        rd(2'd0, rv); chk("ack_pend", rv, 32'h20);
        rd(2'd3, rv); chk("ack_stat", rv, 32'h0A);
        wr(2'd3, 32'h0);
        tick();
        chk("eoi_ir_out", {31'b0, ir_out}, 32'd1);
        chk("eoi_id5", {29'b0, irq_id}, 32'd5);
        ack();
        wr(2'd3, 32'h0);
        tick();

        // Masking
        wr(2'd1, 32'h00);
        pulse(8'h02);
        tick();
        chk("mask_ir_out", {31'b0, ir_out}, 32'd0);
        rd(2'd0, rv); chk("mask_pend", rv, 32'h02);
        wr(2'd1, 32'h02);
        tick();
        chk("unmask_ir_out", {31'b0, ir_out}, 32'd1);
        chk("unmask_id1", {29'b0, irq_id}, 32'd1);
        ack();
        wr(2'd3, 32'h0);

        // Level drop before ack
        wr(2'd2, 32'h00);
        wr(2'd1, 32'h01);
        irq_src = 8'h01;
        repeat (S + 1) tick();
        chk("lvl_ir_out", {31'b0, ir_out}, 32'd1);
        irq_src = 8'h00;
        repeat (S + 1) tick();
        chk("lvl_drop", {31'b0, ir_out}, 32'd0);
        ack();
        chk("lvl_late_ack", {31'b0, ir_out}, 32'd0);
        rd(2'd3, rv); chk("lvl_stat", rv, 32'h00);

        // Set-wins collision on bit 4
        wr(2'd2, 32'hFF);
        wr(2'd1, 32'hFF);
        pulse(8'h10);
        tick();
        chk("sw_ir_out", {31'b0, ir_out}, 32'd1);
        chk("sw_id4", {29'b0, irq_id}, 32'd4);
        irq_src = 8'h10;
        repeat (S) tick();
        ack();
        irq_src = 8'h00;
        rd(2'd0, rv); chk("sw_pend", rv, 32'h10);
        rd(2'd3, rv); chk("sw_stat", rv, 32'h0C);
        wr(2'd3, 32'h0);
        tick();
        chk("sw_reassert", {31'b0, ir_out}, 32'd1);
        chk("sw_reassert_id", {29'b0, irq_id}, 32'd4);
        ack();
        wr(2'd3, 32'h0);
        tick();

        // Ignored strobes
        wr(2'd3, 32'h0);
        chk("eoi_idle_ir_out", {31'b0, ir_out}, 32'd0);
        rd(2'd3, rv); chk("eoi_idle_stat", rv, 32'h04);
        pulse(8'h40);
        tick();
        ack();
        ack();
        chk("ack_svc_ir_out", {31'b0, ir_out}, 32'd0);
        rd(2'd3, rv); chk("ack_svc_stat", rv, 32'h0E);
        wr(2'd3, 32'h0);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 7) == 0) irq_src[b] = ~irq_src[b];
            ir_ack   = ($urandom_range(0, 3) == 0);
            cfg_we   = ($urandom_range(0, 5) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            cfg_din  = $urandom;
            tick();
        end
        ir_ack = 1'b0;
        cfg_we = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
